// File: rtl/uart_pkg.sv
// Definitions shared across the UART receive path: frame geometry and the
// receive controller's state encoding.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int FRAME_BITS = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_LOAD  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/rx_controller.sv
// UART receive sequencer: finds the start bit, pulses shift_en at each
// mid-bit, then issues a single load pulse once the whole frame is shifted in.
module rx_controller #(
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE,
    parameter int FRAME_BITS = uart_pkg::FRAME_BITS,
    parameter int CNT_W      = 4,
    parameter int BIT_W      = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic baud_tick,
    input  logic rx_in,
    output logic shift_en,
    output logic load,
    output logic busy,
    output logic start_err
);
    import uart_pkg::*;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);

    rx_state_t        r_state;
    logic [CNT_W-1:0] r_sample_cnt;
    logic [BIT_W-1:0] r_bit_cnt;
    logic             r_shift_en;
    logic             r_load;
    logic             r_busy;
    logic             r_start_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_sample_cnt <= '0;
            r_bit_cnt    <= '0;
            r_shift_en   <= 1'b0;
            r_load       <= 1'b0;
            r_busy       <= 1'b0;
            r_start_err  <= 1'b0;
        end else begin
            r_shift_en  <= 1'b0;
            r_load      <= 1'b0;
            r_start_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (baud_tick && !rx_in) begin
                        r_state      <= ST_START;
                        r_sample_cnt <= '0;
                        r_busy       <= 1'b1;
                    end
                end
                ST_START: begin
                    if (baud_tick) begin
                        if (r_sample_cnt == HALF_LAST) begin
                            // Line back high at mid start bit means it was a glitch.
                            if (rx_in) begin
                                r_start_err <= 1'b1;
                                r_busy      <= 1'b0;
                                r_state     <= ST_IDLE;
                            end else begin
                                r_sample_cnt <= '0;
                                r_bit_cnt    <= '0;
                                r_state      <= ST_DATA;
                            end
                        end else begin
                            r_sample_cnt <= r_sample_cnt + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        if (r_sample_cnt == FULL_LAST) begin
                            r_sample_cnt <= '0;
                            r_shift_en   <= 1'b1;
                            if (r_bit_cnt == BIT_LAST) begin
                                r_state <= ST_LOAD;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end else begin
                            r_sample_cnt <= r_sample_cnt + 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    // One clk after the last shift, so the shift register has settled.
                    r_load    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_bit_cnt <= '0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign shift_en  = r_shift_en;
    assign load      = r_load;
    assign busy      = r_busy;
    assign start_err = r_start_err;

endmodule

// File: tb/tb_rx_controller.sv
// Self-checking bench for rx_controller: directed and random serial traffic
// compared cycle by cycle against a tick-count model of frame timing.
module tb_rx_controller;
    import uart_pkg::*;

    localparam int OS = OVERSAMPLE;
    localparam int FB = FRAME_BITS;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic baud_tick = 1'b0;
    logic rx_in = 1'b1;
    logic shift_en, load, busy, start_err;

    rx_controller dut (
        .clk       (clk),
        .reset     (reset),
        .baud_tick (baud_tick),
        .rx_in     (rx_in),
        .shift_en  (shift_en),
        .load      (load),
        .busy      (busy),
        .start_err (start_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: position in a frame is just the number of ticks since the start
    // was detected; events fall at fixed tick offsets from that point.
    int m_mode = 0;    // 0 idle, 1 in frame, 2 load pending
    int m_ticks = 0;

    int n_shift, n_load, n_err, cap_idx;
    logic [FB-1:0] cap;
    logic [FB-1:0] last_word;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clr();
        n_shift = 0; n_load = 0; n_err = 0; cap_idx = 0;
        cap = '0; last_word = '0;
    endtask

    task automatic step(input logic tick, input logic rx, input logic rst_n);
        logic e_shift, e_load, e_err, e_busy;
        baud_tick = tick;
        rx_in     = rx;
        reset     = rst_n;
        @(posedge clk);
        e_shift = 1'b0; e_load = 1'b0; e_err = 1'b0;
        if (!rst_n) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (tick && !rx) begin
                m_mode  = 1;
                m_ticks = 0;
            end
        end else if (m_mode == 1) begin
            if (tick) begin
                m_ticks++;
                if (m_ticks == OS / 2 && rx) begin
                    e_err  = 1'b1;
                    m_mode = 0;
                end else if (m_ticks > OS / 2 && (m_ticks - OS / 2) % OS == 0) begin
                    e_shift = 1'b1;
                    if (m_ticks == OS / 2 + FB * OS) m_mode = 2;
                end
            end
        end else begin
            e_load = 1'b1;
            m_mode = 0;
        end
        e_busy = (m_mode != 0);
        @(negedge clk);
        check("outputs{shift,load,busy,err}", {28'b0, shift_en, load, busy, start_err},
              {28'b0, e_shift, e_load, e_busy, e_err});
        if (shift_en === 1'b1) begin
            n_shift++;
            if (cap_idx < FB) cap[cap_idx] = rx_in;
            cap_idx++;
        end
        if (load === 1'b1) begin
            n_load++;
            last_word = cap;
            cap_idx   = 0;
        end
        if (start_err === 1'b1) n_err++;
    endtask

    // n ticks with the line at rx; period 0 picks a random 1..4 clk spacing per tick.
    task automatic ticks(input logic rx, input int n, input int period);
        for (int t = 0; t < n; t++) begin
            int p;
            p = (period == 0) ? int'($urandom_range(1, 4)) : period;
            for (int c = 1; c <= p; c++) step(c == p, rx, 1'b1);
        end
    endtask

    task automatic send_frame(input logic [FB-1:0] bits, input int stop_len, input int period);
        ticks(1'b0, OS, period);
        for (int i = 0; i < FB - 1; i++) ticks(bits[i], OS, period);
        ticks(bits[FB-1], stop_len, period);
    endtask

    function automatic logic [FB-1:0] mk(input logic [6:0] d);
        return {1'b1, ^d, d};
    endfunction

    initial begin
        logic [FB-1:0] f1, f2;
        clr();

        // Reset state
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        check("reset_outs", {28'b0, shift_en, load, busy, start_err}, 32'd0);
        ticks(1'b1, 4, 1);

        // Nominal 0x55 frame
        clr();
        f1 = mk(7'h55);
        check("nominal_frame_const", {23'b0, f1}, 32'h155);
        send_frame(f1, OS, 1);
        ticks(1'b1, OS, 1);
        check("nominal_shifts", n_shift, FB);
        check("nominal_loads", n_load, 1);
        check("nominal_errs", n_err, 0);
        check("nominal_word", {23'b0, last_word}, {23'b0, f1});
        check("nominal_busy_end", {31'b0, busy}, 32'd0);

        // False start: 5 low ticks then high
        clr();
        ticks(1'b0, 5, 1);
        ticks(1'b1, 2 * OS, 1);
        check("false_errs", n_err, 1);
        check("false_shifts", n_shift, 0);
        check("false_loads", n_load, 0);
        check("false_busy_end", {31'b0, busy}, 32'd0);

        // Back-to-back: second start one tick after the stop midpoint
        clr();
        f1 = mk(7'h2A);
        f2 = mk(7'h63);
        send_frame(f1, OS / 2 + 1, 1);
        send_frame(f2, OS, 1);
        ticks(1'b1, OS, 1);
        check("b2b_shifts", n_shift, 2 * FB);
        check("b2b_loads", n_load, 2);
        check("b2b_errs", n_err, 0);
        check("b2b_word", {23'b0, last_word}, {23'b0, f2});

        // Tick every 3rd clk
        clr();
        f1 = mk(7'h55);
        send_frame(f1, OS, 3);
        ticks(1'b1, OS, 3);
        check("gap_shifts", n_shift, FB);
        check("gap_loads", n_load, 1);
        check("gap_word", {23'b0, last_word}, {23'b0, f1});

        // Reset held 3 clks in DATA with bit_cnt==4
        clr();
        ticks(1'b0, OS, 1);
        for (int i = 0; i < 4; i++) ticks(logic'(i % 2), OS, 1);
        ticks(1'b0, 4, 1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        check("midrst_outs", {28'b0, shift_en, load, busy, start_err}, 32'd0);
        ticks(1'b1, 12 * OS, 1);
        check("midrst_shifts", n_shift, 4);
        check("midrst_loads", n_load, 0);

        // Break: line low for 40 bit times
        clr();
        ticks(1'b0, 40 * OS, 1);
        ticks(1'b1, 12 * OS, 1);
        check("break_loaded", {31'b0, n_load >= 1}, 32'd1);
        check("break_shift_per_load", n_shift, n_load * FB);
        check("break_errs", n_err, 0);
        check("break_busy_end", {31'b0, busy}, 32'd0);

        // Random traffic: frames, glitches, truncated stops, resets, tick jitter
        for (int it = 0; it < 40; it++) begin
            int r, per;
            r   = int'($urandom_range(0, 9));
            per = (it % 3 == 0) ? 1 : ((it % 3 == 1) ? 3 : 0);
            if (r < 2) begin
                ticks(1'b0, int'($urandom_range(1, OS / 2 - 1)), per);
                ticks(1'b1, OS, per);
            end else if (r == 2) begin
                ticks(1'b0, OS, per);
                ticks(logic'($urandom_range(0, 1)), int'($urandom_range(1, 60)), per);
                for (int i = 0; i < int'($urandom_range(1, 3)); i++) step(1'b0, 1'b1, 1'b0);
                ticks(1'b1, 12 * OS, per);
            end else begin
                f1 = mk(7'($urandom));
                send_frame(f1, ($urandom_range(0, 1) == 1) ? OS / 2 + 1 : OS, per);
                ticks(1'b1, int'($urandom_range(0, 20)), per);
            end
        end
        ticks(1'b1, 12 * OS, 1);
        check("final_busy", {31'b0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
